// File: rtl/wb_commit_checker_if.sv
`default_nettype none
// ============================================================================
// Module      : wb_commit_checker_if
// Description : Writeback streams of the DUT core and the golden core, plus
//               the checker's status and first-mismatch evidence.
// Revision    : 1.0 - initial release
// ============================================================================
interface wb_commit_checker_if #(
  parameter int DATA_SIZE = 32,
  parameter int CNT_W     = 32
);
  logic                 dut_wb_valid;
  logic [4:0]           dut_wb_rd;
  logic [DATA_SIZE-1:0] dut_wb_data;
  logic                 gold_wb_valid;
  logic [4:0]           gold_wb_rd;
  logic [DATA_SIZE-1:0] gold_wb_data;
  logic [CNT_W-1:0]     match_count;
  logic                 mismatch;
  logic                 overflow;
  logic                 in_sync;
  logic [4:0]           err_rd_dut;
  logic [4:0]           err_rd_gold;
  logic [DATA_SIZE-1:0] err_data_dut;
  logic [DATA_SIZE-1:0] err_data_gold;
  logic                 timeout;

  // Stream source / status observer
  modport master (
    output dut_wb_valid, dut_wb_rd, dut_wb_data,
    output gold_wb_valid, gold_wb_rd, gold_wb_data,
    input  match_count, mismatch, overflow, in_sync,
    input  err_rd_dut, err_rd_gold, err_data_dut, err_data_gold, timeout
  );

  // Checker side
  modport slave (
    input  dut_wb_valid, dut_wb_rd, dut_wb_data,
    input  gold_wb_valid, gold_wb_rd, gold_wb_data,
    output match_count, mismatch, overflow, in_sync,
    output err_rd_dut, err_rd_gold, err_data_dut, err_data_gold, timeout
  );
endinterface
`default_nettype wire

// File: rtl/wb_commit_checker.sv
`default_nettype none
// ============================================================================
// Module      : wb_commit_checker
// Description : Lockstep register-writeback checker. Buffers the DUT and
//               golden writeback streams in separate FIFOs, compares heads in
//               program order and latches a sticky mismatch with evidence.
//               Optional stall watchdog enabled by macro WB_CHECK_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_commit_checker #(
  parameter int DATA_SIZE = 32,
  parameter int DEPTH     = 8,
  parameter int CNT_W     = 32,
  parameter int TIMEOUT   = 64
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clear_i,
  wb_commit_checker_if.slave wb
);
  localparam int               PTR_W    = $clog2(DEPTH);
  localparam int               ENTRY_W  = 5 + DATA_SIZE;
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_param_check
    $error("wb_commit_checker: DEPTH must be a power of two >= 2, TIMEOUT >= 1");
  end

  typedef enum logic [0:0] {ST_RUN = 1'b0, ST_FAIL = 1'b1} state_t;

  state_t               state_q, state_d;
  logic [ENTRY_W-1:0]   dut_mem_q  [DEPTH];
  logic [ENTRY_W-1:0]   gold_mem_q [DEPTH];
  logic [PTR_W-1:0]     dut_wr_q, dut_wr_d, dut_rd_q, dut_rd_d;
  logic [PTR_W-1:0]     gold_wr_q, gold_wr_d, gold_rd_q, gold_rd_d;
  logic [PTR_W:0]       dut_cnt_q, dut_cnt_d, gold_cnt_q, gold_cnt_d;
  logic [CNT_W-1:0]     match_count_q, match_count_d;
  logic                 mismatch_q, mismatch_d, overflow_q, overflow_d;
  logic [4:0]           err_rd_dut_q, err_rd_dut_d, err_rd_gold_q, err_rd_gold_d;
  logic [DATA_SIZE-1:0] err_data_dut_q, err_data_dut_d, err_data_gold_q, err_data_gold_d;

  // x0 writes are architecturally void and never enter a FIFO; FAIL freezes intake
  logic w_run, w_dut_req, w_gold_req, w_pop, w_dut_push, w_gold_push;
  logic w_dut_ovf, w_gold_ovf, w_eq, w_timeout_hit;
  logic [ENTRY_W-1:0] w_dut_head, w_gold_head;

  assign w_run       = (state_q == ST_RUN);
  assign w_dut_req   = w_run && wb.dut_wb_valid && (wb.dut_wb_rd != 5'd0);
  assign w_gold_req  = w_run && wb.gold_wb_valid && (wb.gold_wb_rd != 5'd0);
  assign w_pop       = w_run && (dut_cnt_q != '0) && (gold_cnt_q != '0);
  // A full FIFO may still accept a push when its head leaves on the same edge
  assign w_dut_push  = w_dut_req && ((dut_cnt_q != FULL_CNT) || w_pop);
  assign w_gold_push = w_gold_req && ((gold_cnt_q != FULL_CNT) || w_pop);
  assign w_dut_ovf   = w_dut_req && (dut_cnt_q == FULL_CNT) && !w_pop;
  assign w_gold_ovf  = w_gold_req && (gold_cnt_q == FULL_CNT) && !w_pop;
  assign w_dut_head  = dut_mem_q[dut_rd_q];
  assign w_gold_head = gold_mem_q[gold_rd_q];
  assign w_eq        = (w_dut_head == w_gold_head);

  // FIFO storage; stale contents are harmless because pointers define validity
  always_ff @(posedge clk_i) begin
    if (w_dut_push)  dut_mem_q[dut_wr_q]   <= {wb.dut_wb_rd, wb.dut_wb_data};
    if (w_gold_push) gold_mem_q[gold_wr_q] <= {wb.gold_wb_rd, wb.gold_wb_data};
  end

  // Next-state: pointers, occupancy, compare result and FSM transition
  always_comb begin
    state_d         = state_q;
    dut_wr_d        = dut_wr_q;
    dut_rd_d        = dut_rd_q;
    gold_wr_d       = gold_wr_q;
    gold_rd_d       = gold_rd_q;
    match_count_d   = match_count_q;
    mismatch_d      = mismatch_q;
    overflow_d      = overflow_q;
    err_rd_dut_d    = err_rd_dut_q;
    err_rd_gold_d   = err_rd_gold_q;
    err_data_dut_d  = err_data_dut_q;
    err_data_gold_d = err_data_gold_q;
    dut_cnt_d  = dut_cnt_q + {{PTR_W{1'b0}}, w_dut_push} - {{PTR_W{1'b0}}, w_pop};
    gold_cnt_d = gold_cnt_q + {{PTR_W{1'b0}}, w_gold_push} - {{PTR_W{1'b0}}, w_pop};
    if (w_dut_push)  dut_wr_d  = dut_wr_q + PTR_W'(1);
    if (w_gold_push) gold_wr_d = gold_wr_q + PTR_W'(1);
    if (w_pop) begin
      dut_rd_d  = dut_rd_q + PTR_W'(1);
      gold_rd_d = gold_rd_q + PTR_W'(1);
      if (w_eq) begin
        if (match_count_q != CNT_MAX) match_count_d = match_count_q + CNT_W'(1);
      end else begin
        mismatch_d      = 1'b1;
        err_rd_dut_d    = w_dut_head[ENTRY_W-1 -: 5];
        err_rd_gold_d   = w_gold_head[ENTRY_W-1 -: 5];
        err_data_dut_d  = w_dut_head[DATA_SIZE-1:0];
        err_data_gold_d = w_gold_head[DATA_SIZE-1:0];
      end
    end
    if (w_dut_ovf || w_gold_ovf) overflow_d = 1'b1;
    if ((w_pop && !w_eq) || w_dut_ovf || w_gold_ovf || w_timeout_hit) state_d = ST_FAIL;
  end

  // State register; RESET is asynchronous, CLEAR has the same effect synchronously
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i || clear_i) begin
      state_q         <= ST_RUN;
      dut_wr_q        <= '0;
      dut_rd_q        <= '0;
      gold_wr_q       <= '0;
      gold_rd_q       <= '0;
      dut_cnt_q       <= '0;
      gold_cnt_q      <= '0;
      match_count_q   <= '0;
      mismatch_q      <= 1'b0;
      overflow_q      <= 1'b0;
      err_rd_dut_q    <= '0;
      err_rd_gold_q   <= '0;
      err_data_dut_q  <= '0;
      err_data_gold_q <= '0;
    end else begin
      state_q         <= state_d;
      dut_wr_q        <= dut_wr_d;
      dut_rd_q        <= dut_rd_d;
      gold_wr_q       <= gold_wr_d;
      gold_rd_q       <= gold_rd_d;
      dut_cnt_q       <= dut_cnt_d;
      gold_cnt_q      <= gold_cnt_d;
      match_count_q   <= match_count_d;
      mismatch_q      <= mismatch_d;
      overflow_q      <= overflow_d;
      err_rd_dut_q    <= err_rd_dut_d;
      err_rd_gold_q   <= err_rd_gold_d;
      err_data_dut_q  <= err_data_dut_d;
      err_data_gold_q <= err_data_gold_d;
    end
  end

`ifdef WB_CHECK_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT + 1);
  logic [STALL_W-1:0] stall_q, stall_d;
  logic               timeout_q, timeout_d;
  logic               w_one_pending;

  // Exactly one stream has pending entries while the other is silent
  assign w_one_pending = (dut_cnt_q != '0) != (gold_cnt_q != '0);
  assign w_timeout_hit = w_run && w_one_pending && (stall_q == STALL_W'(TIMEOUT - 1));

  // Stall watchdog: counts one-sided cycles, cleared by a pop or both empty
  always_comb begin
    stall_d   = stall_q;
    timeout_d = timeout_q;
    if (w_run) stall_d = w_one_pending ? stall_q + STALL_W'(1) : '0;
    if (w_timeout_hit) timeout_d = 1'b1;
  end

  // Watchdog registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i || clear_i) begin
      stall_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      stall_q   <= stall_d;
      timeout_q <= timeout_d;
    end
  end

  assign wb.timeout = timeout_q;
`else
  assign w_timeout_hit = 1'b0;
  assign wb.timeout    = 1'b0;
`endif

  assign wb.match_count   = match_count_q;
  assign wb.mismatch      = mismatch_q;
  assign wb.overflow      = overflow_q;
  assign wb.in_sync       = w_run && (dut_cnt_q == '0) && (gold_cnt_q == '0);
  assign wb.err_rd_dut    = err_rd_dut_q;
  assign wb.err_rd_gold   = err_rd_gold_q;
  assign wb.err_data_dut  = err_data_dut_q;
  assign wb.err_data_gold = err_data_gold_q;
endmodule
`default_nettype wire

// File: tb/tb_wb_commit_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_commit_checker
// Description : Self-checking bench for wb_commit_checker (DEPTH=4): directed
//               scenarios plus randomized paired streams against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_commit_checker;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int CW    = 32;
  localparam int TO    = 64;

  logic clk = 1'b0;
  logic rst_i, clear_i;
  int   n_tests = 0;
  int   n_fail  = 0;

  wb_commit_checker_if #(.DATA_SIZE(DW), .CNT_W(CW)) wb_if ();

  wb_commit_checker #(.DATA_SIZE(DW), .DEPTH(DEPTH), .CNT_W(CW), .TIMEOUT(TO)) u_dut (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .clear_i (clear_i),
    .wb      (wb_if)
  );

  always #5 clk = ~clk;

  // Reference model: two queues of {rd,data} plus sticky status
  logic [36:0]   dq[$];
  logic [36:0]   gq[$];
  bit            m_failed, m_mis, m_ovf, m_to;
  logic [CW-1:0] m_cnt;
  logic [4:0]    m_erd_d, m_erd_g;
  logic [DW-1:0] m_ed_d, m_ed_g;
  int            m_stall;

  task automatic model_reset();
    dq.delete(); gq.delete();
    m_failed = 0; m_mis = 0; m_ovf = 0; m_to = 0; m_cnt = '0;
    m_erd_d = '0; m_erd_g = '0; m_ed_d = '0; m_ed_g = '0; m_stall = 0;
  endtask

  task automatic model_edge(input bit dv, input logic [4:0] drd, input logic [DW-1:0] dd,
                            input bit gv, input logic [4:0] grd, input logic [DW-1:0] gd,
                            input bit clr);
    int dn, gn; bit pop, nf;
    logic [36:0] dh, gh;
    if (clr) begin model_reset(); return; end
    if (m_failed) return;
    dn = dq.size(); gn = gq.size(); pop = (dn > 0) && (gn > 0); nf = 0;
`ifdef WB_CHECK_TIMEOUT_EN
    if ((dn > 0) != (gn > 0)) begin
      m_stall++;
      if (m_stall >= TO) begin m_to = 1; nf = 1; end
    end else m_stall = 0;
`endif
    if (pop) begin
      dh = dq.pop_front(); gh = gq.pop_front();
      if (dh == gh) begin
        if (m_cnt != {CW{1'b1}}) m_cnt = m_cnt + 1;
      end else begin
        m_mis = 1; nf = 1;
        m_erd_d = dh[36:32]; m_ed_d = dh[31:0];
        m_erd_g = gh[36:32]; m_ed_g = gh[31:0];
      end
    end
    if (dv && drd != 0) begin
      if (dn == DEPTH && !pop) begin m_ovf = 1; nf = 1; end
      else dq.push_back({drd, dd});
    end
    if (gv && grd != 0) begin
      if (gn == DEPTH && !pop) begin m_ovf = 1; nf = 1; end
      else gq.push_back({grd, gd});
    end
    if (nf) m_failed = 1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "/match_count"}, 64'(wb_if.match_count), 64'(m_cnt));
    chk({tag, "/mismatch"}, 64'(wb_if.mismatch), 64'(m_mis));
    chk({tag, "/overflow"}, 64'(wb_if.overflow), 64'(m_ovf));
    chk({tag, "/in_sync"}, 64'(wb_if.in_sync), 64'(!m_failed && dq.size() == 0 && gq.size() == 0));
    chk({tag, "/err_rd"}, {54'd0, wb_if.err_rd_dut, wb_if.err_rd_gold}, {54'd0, m_erd_d, m_erd_g});
    chk({tag, "/err_data"}, {wb_if.err_data_dut, wb_if.err_data_gold}, {m_ed_d, m_ed_g});
    chk({tag, "/timeout"}, 64'(wb_if.timeout), 64'(m_to));
  endtask

  task automatic step(input string tag, input bit dv, input logic [4:0] drd, input logic [DW-1:0] dd,
                      input bit gv, input logic [4:0] grd, input logic [DW-1:0] gd, input bit clr);
    wb_if.dut_wb_valid  = dv; wb_if.dut_wb_rd  = drd; wb_if.dut_wb_data  = dd;
    wb_if.gold_wb_valid = gv; wb_if.gold_wb_rd = grd; wb_if.gold_wb_data = gd;
    clear_i = clr;
    @(posedge clk);
    model_edge(dv, drd, dd, gv, grd, gd, clr);
    #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag, input int n);
    repeat (n) step(tag, 0, 5'd0, '0, 0, 5'd0, '0, 0);
  endtask

  initial begin
    logic [36:0] items[30];
    logic [36:0] ditem;
    int di, gi, cyc;
    bit dv, gv;
    logic exp_to;

    // Reset state
    rst_i = 1'b1; clear_i = 1'b0;
    wb_if.dut_wb_valid = 0; wb_if.dut_wb_rd = '0; wb_if.dut_wb_data = '0;
    wb_if.gold_wb_valid = 0; wb_if.gold_wb_rd = '0; wb_if.gold_wb_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    chk("reset/in_sync_const", 64'(wb_if.in_sync), 64'd1);
    #2 rst_i = 1'b0;

    // 1: DUT x1=5 at cycle 2, golden x1=5 at cycle 6
    idle("t1", 2);
    step("t1_dut", 1, 5'd1, 32'd5, 0, 5'd0, '0, 0);
    idle("t1", 3);
    step("t1_gold", 0, 5'd0, '0, 1, 5'd1, 32'd5, 0);
    chk("t1_latency", 64'(wb_if.match_count), 64'd0);
    idle("t1", 1);
    chk("t1_match", 64'(wb_if.match_count), 64'd1);
    chk("t1_insync", 64'(wb_if.in_sync), 64'd1);

    // 2: x2 data 8 vs 9 -> mismatch with evidence; later pair is ignored
    step("t2_pair", 1, 5'd2, 32'd8, 1, 5'd2, 32'd9, 0);
    idle("t2", 1);
    chk("t2_mismatch", 64'(wb_if.mismatch), 64'd1);
    chk("t2_err", {wb_if.err_rd_dut, wb_if.err_rd_gold, wb_if.err_data_dut, wb_if.err_data_gold},
        {5'd2, 5'd2, 32'd8, 32'd9});
    step("t2_after", 1, 5'd3, 32'd7, 1, 5'd3, 32'd7, 0);
    idle("t2", 2);
    chk("t2_frozen", 64'(wb_if.match_count), 64'd1);
    step("t2_clear", 0, 5'd0, '0, 0, 5'd0, '0, 1);

    // 3: x0 writes are filtered
    step("t3_x0", 1, 5'd0, 32'd1, 1, 5'd0, 32'd2, 0);
    idle("t3", 2);
    chk("t3_x0", {wb_if.match_count, 31'd0, wb_if.mismatch}, {32'd0, 31'd0, 1'b0});
    chk("t3_insync", 64'(wb_if.in_sync), 64'd1);

    // 4: five DUT writes into a 4-deep FIFO
    for (int i = 1; i <= 4; i++) step("t4_fill", 1, 5'(i), 32'(i * 3), 0, 5'd0, '0, 0);
    chk("t4_no_ovf", 64'(wb_if.overflow), 64'd0);
    step("t4_ovf", 1, 5'd5, 32'd15, 0, 5'd0, '0, 0);
    chk("t4_ovf", 64'(wb_if.overflow), 64'd1);
    chk("t4_fail", 64'(wb_if.in_sync), 64'd0);
    step("t4_clear", 0, 5'd0, '0, 0, 5'd0, '0, 1);

    // 5: 20 matching pairs, golden leading by 3 cycles
    for (int c = 0; c < 23; c++)
      step("t5", c >= 3, 5'(((c - 3) % 31) + 1), 32'(c * 11 - 33), c < 20, 5'((c % 31) + 1), 32'(c * 11), 0);
    idle("t5", 2);
    chk("t5_count", 64'(wb_if.match_count), 64'd20);
    chk("t5_no_ovf", 64'(wb_if.overflow), 64'd0);

    // 6: async RESET with 3 queued entries, then CLEAR after 2 more
    for (int i = 0; i < 3; i++) step("t6_q", 1, 5'(i + 4), 32'(i), 0, 5'd0, '0, 0);
    rst_i = 1'b1;
    #2;
    model_reset();
    check_all("t6_async_rst");
    chk("t6_rst_insync", 64'(wb_if.in_sync), 64'd1);
    rst_i = 1'b0;
    for (int i = 0; i < 2; i++) step("t6_q2", 1, 5'(i + 9), 32'(i), 0, 5'd0, '0, 0);
    chk("t6_pending", 64'(wb_if.in_sync), 64'd0);
    step("t6_clear", 0, 5'd0, '0, 0, 5'd0, '0, 1);
    chk("t6_clear_insync", 64'(wb_if.in_sync), 64'd1);
    idle("t6", 2);

    // Stall watchdog: one lone DUT entry
    step("to_push", 1, 5'd3, 32'h77, 0, 5'd0, '0, 0);
    idle("to_wait", 63);
    chk("to_early", 64'(wb_if.timeout), 64'd0);
    idle("to_edge", 1);
`ifdef WB_CHECK_TIMEOUT_EN
    exp_to = 1'b1;
`else
    exp_to = 1'b0;
`endif
    chk("to_hit", 64'(wb_if.timeout), 64'(exp_to));
    step("to_clear", 0, 5'd0, '0, 0, 5'd0, '0, 1);

    // Randomized paired streams with occasional corruption
    for (int r = 0; r < 8; r++) begin
      foreach (items[k]) items[k] = {5'($urandom_range(0, 7)), 32'($urandom)};
      di = 0; gi = 0; cyc = 0;
      while ((di < 30 || gi < 30) && cyc < 200) begin
        dv = (di < 30) && ($urandom_range(0, 2) != 0);
        gv = (gi < 30) && ($urandom_range(0, 2) != 0);
        ditem = dv ? items[di] : '0;
        if (dv && $urandom_range(0, 39) == 0) ditem[0] = ~ditem[0];
        step("rand", dv, ditem[36:32], ditem[31:0], gv,
             gv ? items[gi][36:32] : 5'd0, gv ? items[gi][31:0] : 32'd0, 0);
        if (dv) di++;
        if (gv) gi++;
        cyc++;
      end
      idle("rand_drain", 3);
      step("rand_clear", 0, 5'd0, '0, 0, 5'd0, '0, 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
